// File: rtl/a0_trace_fifo.sv
// Trace buffer for the core's a0 output: stores each new a0 value with a capture
// sequence number in a circular FIFO and drains it through a valid/ready port.
module a0_trace_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic [WIDTH-1:0]         a0_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [SEQ_W-1:0]         overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [SEQ_W-1:0] seq_mem  [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [SEQ_W-1:0] seq_cnt;
    logic [SEQ_W-1:0] ovf_q;
    logic [WIDTH-1:0] prev_a0;
    logic             primed;

    logic capture;
    logic pop;
    logic push;
    logic drop;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign count        = count_q;
    assign overflow_cnt = ovf_q;
    assign out_valid    = !empty;

    // Storage is never exposed while empty so stale entries cannot leak out.
    assign out_data = empty ? '0 : data_mem[rd_ptr];
    assign out_seq  = empty ? '0 : seq_mem[rd_ptr];

    always_comb begin
        capture = !clear && en && (!primed || (a0_in != prev_a0));
        pop     = !clear && out_valid && out_ready;
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            seq_cnt <= '0;
            ovf_q   <= '0;
            prev_a0 <= '0;
            primed  <= 1'b0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            seq_cnt <= '0;
            ovf_q   <= '0;
            primed  <= 1'b0;
        end else begin
            if (en) begin
                prev_a0 <= a0_in;
                primed  <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            // Dropped captures still consume a sequence number so gaps reveal them.
            if (capture) begin
                seq_cnt <= seq_cnt + SEQ_W'(1);
            end
            if (drop && (ovf_q != {SEQ_W{1'b1}})) begin
                ovf_q <= ovf_q + SEQ_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= a0_in;
            seq_mem[wr_ptr]  <= seq_cnt;
        end
    end

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Self-checking bench for a0_trace_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_a0_trace_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int SEQ_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              en;
    logic [WIDTH-1:0]  a0_in;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [SEQ_W-1:0]  out_seq;
    logic [$clog2(DEPTH):0] count;
    logic              full;
    logic              empty;
    logic [SEQ_W-1:0]  overflow_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    bit [WIDTH-1:0] m_data[$];
    bit [SEQ_W-1:0] m_seq[$];
    bit [WIDTH-1:0] m_prev;
    bit             m_primed;
    bit [SEQ_W-1:0] m_seqcnt;
    bit [SEQ_W-1:0] m_ovf;

    a0_trace_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .en(en), .a0_in(a0_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_seq(out_seq), .count(count), .full(full), .empty(empty),
        .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset(input bit hard);
        m_data.delete();
        m_seq.delete();
        m_primed = 1'b0;
        m_seqcnt = '0;
        m_ovf    = '0;
        if (hard) m_prev = '0;
    endtask

    // Compare every DUT output against the model's current view.
    task automatic checkAll(input string tag);
        int n;
        n = m_data.size();
        checkOutput({tag, ".valid"}, 64'(out_valid), 64'(n != 0));
        checkOutput({tag, ".data"}, 64'(out_data), (n != 0) ? 64'(m_data[0]) : 64'd0);
        checkOutput({tag, ".seq"}, 64'(out_seq), (n != 0) ? 64'(m_seq[0]) : 64'd0);
        checkOutput({tag, ".count"}, 64'(count), 64'(n));
        checkOutput({tag, ".full"}, 64'(full), 64'(n == DEPTH));
        checkOutput({tag, ".empty"}, 64'(empty), 64'(n == 0));
        checkOutput({tag, ".ovf"}, 64'(overflow_cnt), 64'(m_ovf));
    endtask

    // Called at a falling edge: drive inputs, advance the model, wait one cycle, check.
    task automatic applyStimulus(input bit c_en, input bit [WIDTH-1:0] c_a0,
                                 input bit c_ready, input bit c_clear, input string tag);
        bit do_pop;
        bit do_cap;
        en        = c_en;
        a0_in     = c_a0;
        out_ready = c_ready;
        clear     = c_clear;
        if (c_clear) begin
            modelReset(1'b0);
        end else begin
            do_pop = (m_data.size() != 0) && c_ready;
            do_cap = c_en && (!m_primed || (c_a0 != m_prev));
            if (c_en) begin
                m_prev   = c_a0;
                m_primed = 1'b1;
            end
            if (do_pop) begin
                void'(m_data.pop_front());
                void'(m_seq.pop_front());
            end
            if (do_cap) begin
                if (m_data.size() < DEPTH) begin
                    m_data.push_back(c_a0);
                    m_seq.push_back(m_seqcnt);
                end else if (m_ovf != {SEQ_W{1'b1}}) begin
                    m_ovf = m_ovf + 1'b1;
                end
                m_seqcnt = m_seqcnt + 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        checkAll(tag);
    endtask

    initial begin
        bit [WIDTH-1:0] s2_vals [6];
        rst = 1'b1; clear = 1'b0; en = 1'b0; a0_in = '0; out_ready = 1'b0;
        modelReset(1'b1);
        repeat (2) @(negedge clk);
        checkOutput("reset.valid", 64'(out_valid), 64'd0);
        checkOutput("reset.empty", 64'(empty), 64'd1);
        rst = 1'b0;
        checkAll("reset");

        // Priming capture
        repeat (5) applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, "prime");
        checkOutput("s1.count", 64'(count), 64'd1);
        checkOutput("s1.seq", 64'(out_seq), 64'd0);

        // Change detection
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, "s2clr");
        s2_vals = '{32'd5, 32'd5, 32'd7, 32'd7, 32'd7, 32'd9};
        foreach (s2_vals[i]) applyStimulus(1'b1, s2_vals[i], 1'b0, 1'b0, "s2cap");
        checkOutput("s2.count", 64'(count), 64'd3);
        checkOutput("s2.head", {32'(out_seq), out_data}, {32'd0, 32'd5});
        applyStimulus(1'b0, 32'd9, 1'b1, 1'b0, "s2drain");
        checkOutput("s2.head2", {32'(out_seq), out_data}, {32'd1, 32'd7});
        repeat (2) applyStimulus(1'b0, 32'd9, 1'b1, 1'b0, "s2drain");

        // Overflow
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, "s3clr");
        for (int v = 1; v <= 20; v++) applyStimulus(1'b1, 32'(v), 1'b0, 1'b0, "s3cap");
        checkOutput("s3.full", 64'(full), 64'd1);
        checkOutput("s3.ovf", 64'(overflow_cnt), 64'd4);
        checkOutput("s3.head", {32'(out_seq), out_data}, {32'd0, 32'd1});

        // Full with simultaneous pop
        applyStimulus(1'b1, 32'd100, 1'b1, 1'b0, "s4");
        checkOutput("s4.count", 64'(count), 64'd16);
        checkOutput("s4.ovf", 64'(overflow_cnt), 64'd4);
        checkOutput("s4.head", {32'(out_seq), out_data}, {32'd1, 32'd2});
        repeat (15) applyStimulus(1'b0, 32'd100, 1'b1, 1'b0, "s4drain");
        checkOutput("s4.tail", {32'(out_seq), out_data}, {32'd20, 32'd100});

        // Clear versus capture
        applyStimulus(1'b1, 32'd55, 1'b1, 1'b1, "s5clr");
        checkOutput("s5.empty", 64'(empty), 64'd1);
        applyStimulus(1'b1, 32'd55, 1'b0, 1'b0, "s5prime");
        checkOutput("s5.head", {32'(out_seq), out_data}, {32'd0, 32'd55});

        // Random traffic with frequent repeats to exercise change detection
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 32'($urandom_range(0, 3)),
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 60) == 0), "rand");
        end

        // Asynchronous reset mid-drain
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, "s6clr");
        for (int v = 1; v <= 19; v++) applyStimulus(1'b1, 32'(v + 200), 1'b0, 1'b0, "s6fill");
        repeat (11) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, "s6drain");
        checkOutput("s6.count", 64'(count), 64'd5);
        checkOutput("s6.ovf", 64'(overflow_cnt), 64'd3);
        #2 rst = 1'b1;
        #1;
        checkOutput("s6.async_valid", 64'(out_valid), 64'd0);
        checkOutput("s6.async_count", 64'(count), 64'd0);
        checkOutput("s6.async_ovf", 64'(overflow_cnt), 64'd0);
        modelReset(1'b1);
        @(negedge clk);
        rst = 1'b0;
        checkAll("s6post");
        applyStimulus(1'b1, 32'd0, 1'b0, 1'b0, "s6prime");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
